instr_encoder: RTL and testbench

Packs decoded instruction fields into the 16-bit instruction word of our CPU and writes the words one after another into instruction memory. It performs the inverse of the opcode decoder. A valid/ready front end feeds a small FIFO, and a sequential memory-write port with an auto-incrementing address drains it. It is used by the program loader and by test benches that build programs from field-level descriptions.

---
 rtl/instr_encoder.sv | 102 ++++++++++
 tb/tb_instr_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 16-bit words, queues them in a
// small FIFO and streams them out through an auto-incrementing write port.
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic              in_setcc,
    input  logic [2:0]        in_rD,
    input  logic [2:0]        in_rA,
    input  logic [2:0]        in_rB,
    input  logic [4:0]        in_immB,
    input  logic              load_base,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              err_illegal,
    output logic [7:0]        err_cnt,
    output logic              busy
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]       wr_q, wr_d, rd_q, rd_d;
    logic [15:0]       fifo_q [DEPTH];
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;

    logic        full, empty, accept, legal, imm_form, push, pop;
    logic [2:0]  ra_f;
    logic [4:0]  low5;
    logic [15:0] word;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PW] != rd_q[PW]) &&
                   (wr_q[PW-1:0] == rd_q[PW-1:0]);

    assign in_ready = !full;
    assign mem_we   = !empty;
    assign busy     = !empty;
    assign accept   = in_valid && in_ready;
    assign pop      = mem_we && mem_ack;

    // Ops 0000/0001 are illegal; odd ops 0011..1101 carry an immediate.
    always_comb begin
        legal    = (in_op[3:1] != 3'b000);
        imm_form = in_op[0] && (in_op >= 4'd3) && (in_op <= 4'd13);
        ra_f     = (in_op[3:1] == 3'b010) ? 3'b000 : in_rA;
        low5     = imm_form ? in_immB : {in_rB, 2'b00};
        word     = {in_op, in_setcc, in_rD, ra_f, low5};
        push     = accept && legal;
    end

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        addr_d = addr_q;
        err_d  = accept && !legal;
        cnt_d  = cnt_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop) begin
            rd_d   = rd_q + 1'b1;
            addr_d = addr_q + 1'b1;
        end
        if (load_base) addr_d = base_addr;
        if (err_d && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            addr_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= 8'd0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            addr_q <= addr_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q[PW-1:0]] <= word;
    end

    // Gate the head so the port reads zero whenever nothing is queued.
    assign mem_wdata   = empty ? 16'h0000 : fifo_q[rd_q[PW-1:0]];
    assign mem_addr    = addr_q;
    assign err_illegal = err_q;
    assign err_cnt     = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding, FIFO fill/drain,
// address wrap/load, illegal-op counting and mid-stream reset.
module tb_instr_encoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid, in_ready;
    logic [3:0] in_op;
    logic       in_setcc;
    logic [2:0] in_rD, in_rA, in_rB;
    logic [4:0] in_immB;
    logic       load_base;
    logic [7:0] base_addr;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [15:0] mem_wdata;
    logic       mem_ack;
    logic       err_illegal;
    logic [7:0] err_cnt;
    logic       busy;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_setcc(in_setcc),
        .in_rD(in_rD), .in_rA(in_rA), .in_rB(in_rB),
        .in_immB(in_immB),
        .load_base(load_base), .base_addr(base_addr),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .err_illegal(err_illegal), .err_cnt(err_cnt),
        .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fields(input logic [3:0] op, input logic sc,
                          input logic [2:0] rd, input logic [2:0] ra,
                          input logic [2:0] rb, input logic [4:0] imm);
        in_op = op; in_setcc = sc; in_rD = rd;
        in_rA = ra; in_rB = rb; in_immB = imm;
    endtask

    task automatic test_reset();
        vecs++; if (mem_we !== 1'b0) begin errs++;
            $display("FAIL rst_we got %0b want 0", mem_we); end
        vecs++; if (mem_addr !== 8'h00) begin errs++;
            $display("FAIL rst_addr got %h want 00", mem_addr); end
        vecs++; if (mem_wdata !== 16'h0000) begin errs++;
            $display("FAIL rst_wdata got %h want 0000", mem_wdata); end
        vecs++; if (in_ready !== 1'b1) begin errs++;
            $display("FAIL rst_ready got %0b want 1", in_ready); end
        vecs++; if (busy !== 1'b0) begin errs++;
            $display("FAIL rst_busy got %0b want 0", busy); end
        vecs++; if (err_illegal !== 1'b0 || err_cnt !== 8'd0) begin errs++;
            $display("FAIL rst_err got %0b/%0d want 0/0", err_illegal, err_cnt); end
    endtask

    task automatic test_add();
        fields(4'b0010, 1'b1, 3'd3, 3'd5, 3'd6, 5'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vecs++; if (mem_we !== 1'b1 || mem_wdata !== 16'h2BB8 || mem_addr !== 8'h00) begin
            errs++; $display("FAIL add_word got we=%0b %h @%h want 1 2BB8 @00",
                             mem_we, mem_wdata, mem_addr); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        vecs++; if (mem_addr !== 8'h01 || busy !== 1'b0) begin errs++;
            $display("FAIL add_ack got @%h busy=%0b want @01 0", mem_addr, busy); end
    endtask

    task automatic test_imm();
        fields(4'b0111, 1'b0, 3'd1, 3'd2, 3'd0, 5'h1F);
        in_valid = 1'b1;
        step();
        vecs++; if (mem_wdata !== 16'h715F) begin errs++;
            $display("FAIL subi got %h want 715F", mem_wdata); end
        fields(4'b0101, 1'b0, 3'd7, 3'd3, 3'd0, 5'd5);
        step();
        in_valid = 1'b0;
        mem_ack = 1'b1;
        step();
        vecs++; if (mem_wdata !== 16'h5705 || mem_addr !== 8'h02) begin errs++;
            $display("FAIL movi got %h @%h want 5705 @02", mem_wdata, mem_addr); end
        step();
        mem_ack = 1'b0;
        vecs++; if (busy !== 1'b0 || mem_addr !== 8'h03) begin errs++;
            $display("FAIL imm_drain got busy=%0b @%h want 0 @03", busy, mem_addr); end
    endtask

    task automatic test_fill();
        logic [15:0] w;
        for (int i = 0; i < 4; i++) begin
            fields(4'b0010, 1'b0, 3'(i), 3'd1, 3'd2, 5'd0);
            in_valid = 1'b1;
            step();
        end
        vecs++; if (in_ready !== 1'b0) begin errs++;
            $display("FAIL fill_full got ready=%0b want 0", in_ready); end
        fields(4'b0010, 1'b0, 3'd4, 3'd1, 3'd2, 5'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        vecs++; if (in_ready !== 1'b1 || mem_wdata !== 16'h2128 || mem_addr !== 8'h04) begin
            errs++; $display("FAIL fill_pop got rdy=%0b %h @%h want 1 2128 @04",
                             in_ready, mem_wdata, mem_addr); end
        step();
        in_valid = 1'b0;
        vecs++; if (in_ready !== 1'b0) begin errs++;
            $display("FAIL fill_5th got ready=%0b want 0", in_ready); end
        mem_ack = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            w = 16'h2028 | (16'(j) << 8);
            vecs++; if (mem_wdata !== w || mem_addr !== 8'(3 + j)) begin errs++;
                $display("FAIL fill_order%0d got %h @%h want %h @%h",
                         j, mem_wdata, mem_addr, w, 8'(3 + j)); end
            step();
        end
        mem_ack = 1'b0;
        vecs++; if (busy !== 1'b0 || mem_addr !== 8'h08) begin errs++;
            $display("FAIL fill_end got busy=%0b @%h want 0 @08", busy, mem_addr); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ea [3];
        ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00;
        load_base = 1'b1; base_addr = 8'hFE;
        step();
        load_base = 1'b0;
        vecs++; if (mem_addr !== 8'hFE) begin errs++;
            $display("FAIL load got @%h want FE", mem_addr); end
        mem_ack = 1'b1;
        in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            fields(4'b0011, 1'b0, 3'(j), 3'd0, 3'd0, 5'(j));
            step();
            vecs++; if (mem_we !== 1'b1 || mem_addr !== ea[j] ||
                        mem_wdata !== (16'h3000 | (16'(j) << 8) | 16'(j))) begin
                errs++; $display("FAIL b2b%0d got we=%0b %h @%h want @%h",
                                 j, mem_we, mem_wdata, mem_addr, ea[j]); end
        end
        in_valid = 1'b0;
        step();
        mem_ack = 1'b0;
        vecs++; if (busy !== 1'b0 || mem_addr !== 8'h01) begin errs++;
            $display("FAIL wrap_end got busy=%0b @%h want 0 @01", busy, mem_addr); end
        load_base = 1'b1; base_addr = 8'hFF;
        fields(4'b0100, 1'b0, 3'd2, 3'd6, 3'd1, 5'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vecs++; if (mem_addr !== 8'hFF || mem_wdata !== 16'h4204) begin errs++;
            $display("FAIL mov_at_ff got %h @%h want 4204 @FF", mem_wdata, mem_addr); end
        base_addr = 8'h10;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; load_base = 1'b0;
        vecs++; if (mem_addr !== 8'h10 || busy !== 1'b0) begin errs++;
            $display("FAIL load_prio got @%h busy=%0b want @10 0", mem_addr, busy); end
    endtask

    task automatic test_illegal();
        fields(4'b0000, 1'b1, 3'd1, 3'd1, 3'd1, 5'd1);
        in_valid = 1'b1;
        step();
        vecs++; if (err_illegal !== 1'b1 || err_cnt !== 8'd1 || mem_we !== 1'b0) begin
            errs++; $display("FAIL ill1 got p=%0b cnt=%0d we=%0b want 1 1 0",
                             err_illegal, err_cnt, mem_we); end
        step();
        in_valid = 1'b0;
        vecs++; if (err_illegal !== 1'b1 || err_cnt !== 8'd2 || mem_we !== 1'b0) begin
            errs++; $display("FAIL ill2 got p=%0b cnt=%0d we=%0b want 1 2 0",
                             err_illegal, err_cnt, mem_we); end
        step();
        vecs++; if (err_illegal !== 1'b0 || err_cnt !== 8'd2) begin errs++;
            $display("FAIL ill_end got p=%0b cnt=%0d want 0 2", err_illegal, err_cnt); end
        in_op = 4'b0001;
        in_valid = 1'b1;
        for (int k = 0; k < 300; k++) step();
        in_valid = 1'b0;
        step();
        vecs++; if (err_cnt !== 8'd255 || busy !== 1'b0) begin errs++;
            $display("FAIL ill_sat got cnt=%0d busy=%0b want 255 0", err_cnt, busy); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            fields(4'b1110, 1'b0, 3'(j), 3'd1, 3'd3, 5'd0);
            step();
        end
        in_valid = 1'b0;
        vecs++; if (busy !== 1'b1) begin errs++;
            $display("FAIL mid_queued got busy=%0b want 1", busy); end
        reset_n = 1'b0;
        #1;
        vecs++; if (mem_we !== 1'b0 || busy !== 1'b0) begin errs++;
            $display("FAIL mid_rst got we=%0b busy=%0b want 0 0", mem_we, busy); end
        step();
        reset_n = 1'b1;
        step();
        step();
        vecs++; if (mem_addr !== 8'h00 || err_cnt !== 8'd0 || mem_we !== 1'b0) begin
            errs++; $display("FAIL mid_rel got @%h cnt=%0d we=%0b want @00 0 0",
                             mem_addr, err_cnt, mem_we); end
        fields(4'b1111, 1'b1, 3'd5, 3'd4, 3'd7, 5'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vecs++; if (mem_wdata !== 16'hFD9C || mem_addr !== 8'h00) begin errs++;
            $display("FAIL rr_after got %h @%h want FD9C @00", mem_wdata, mem_addr); end
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; load_base = 1'b0; base_addr = 8'h00; mem_ack = 1'b0;
        fields(4'h0, 1'b0, 3'd0, 3'd0, 3'd0, 5'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        test_reset();
        test_add();
        test_imm();
        test_fill();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
